// File: rtl/axi4_lite_master_if.sv
// Bundle of the command/response side and AXI4-Lite master channels for axi4_lite_master.
// The master modport is the DUT view; the slave modport is the environment (CPU + AXI slave) view.
interface axi4_lite_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;

  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    output m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_rready
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one buffered response out.
// Define AXIL_MST_TIMEOUT_EN to add a watchdog that reports 2'b10 after TIMEOUT_CYCLES.
module axi4_lite_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi4_lite_master_if.master     bus_io
);

  typedef enum logic [2:0] {
    StIdle, StWrite, StWriteResp, StReadAddr, StReadData, StRsp
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

  logic cmd_ready, bready, rready;
  logic cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;

  assign cmd_ready = (state_q == StIdle) && !ARESET;
  assign bready    = (state_q == StWriteResp);
  assign rready    = (state_q == StReadData);

  assign cmd_hs = bus_io.cmd_valid && cmd_ready;
  assign aw_hs  = awvalid_q && bus_io.m_axi_awready;
  assign w_hs   = wvalid_q && bus_io.m_axi_wready;
  assign ar_hs  = arvalid_q && bus_io.m_axi_arready;
  assign b_hs   = bready && bus_io.m_axi_bvalid;
  assign r_hs   = rready && bus_io.m_axi_rvalid;
  assign rsp_hs = (state_q == StRsp) && bus_io.rsp_ready;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic              busy;

  assign busy = (state_q == StWrite) || (state_q == StWriteResp) ||
                (state_q == StReadAddr) || (state_q == StReadData);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          we_d    = bus_io.cmd_we;
          addr_d  = bus_io.cmd_addr;
          wdata_d = bus_io.cmd_wdata;
          wstrb_d = bus_io.cmd_wstrb;
          if (bus_io.cmd_we) begin
            state_d   = StWrite;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = StReadAddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // BREADY only after both address and data have been taken.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWriteResp;
      end
      StWriteResp: begin
        if (b_hs) begin
          resp_d  = bus_io.m_axi_bresp;
          rdata_d = '0;
          state_d = StRsp;
        end
      end
      StReadAddr: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = StReadData;
        end
      end
      StReadData: begin
        if (r_hs) begin
          rdata_d = bus_io.m_axi_rdata;
          resp_d  = bus_io.m_axi_rresp;
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (rsp_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef AXIL_MST_TIMEOUT_EN
    timer_d = timer_q;
    if (cmd_hs) timer_d = '0;
    else if (busy) timer_d = timer_q + TimerW'(1);

    // A real completion on the expiry cycle already targets StRsp and takes priority.
    if (busy && (timer_q == TimerLast) && (state_d != StRsp)) begin
      state_d   = StRsp;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      resp_d    = 2'b10;
      rdata_d   = '0;
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
`ifdef AXIL_MST_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef AXIL_MST_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  assign bus_io.cmd_ready     = cmd_ready;
  assign bus_io.rsp_valid     = (state_q == StRsp);
  assign bus_io.rsp_we        = we_q;
  assign bus_io.rsp_rdata     = rdata_q;
  assign bus_io.rsp_resp      = resp_q;
  assign bus_io.m_axi_awvalid = awvalid_q;
  assign bus_io.m_axi_awaddr  = addr_q;
  assign bus_io.m_axi_wvalid  = wvalid_q;
  assign bus_io.m_axi_wdata   = wdata_q;
  assign bus_io.m_axi_wstrb   = wstrb_q;
  assign bus_io.m_axi_bready  = bready;
  assign bus_io.m_axi_arvalid = arvalid_q;
  assign bus_io.m_axi_araddr  = addr_q;
  assign bus_io.m_axi_rready  = rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: write/read paths, slave stalls, response hold, reset abort
// and the watchdog (or its absence when AXIL_MST_TIMEOUT_EN is undefined).
module tb_axi4_lite_master;

  logic ACLK = 1'b0;
  logic ARESET;
  int   checks   = 0;
  int   failures = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axi4_lite_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus_io(bus)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_wstrb = strb;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'hFFFF_FFFF;
    bus.cmd_wdata = 32'h5555_5555;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    logic seen;

    ARESET            = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_we        = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.cmd_wstrb     = '0;
    bus.rsp_ready     = 1'b0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;

    tick();
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_awvalid", bus.m_axi_awvalid, 0);
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_fields", {bus.rsp_we, bus.rsp_resp, bus.rsp_rdata}, 0);
    ARESET = 1'b0;
    tick();
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Write 0xDEADBEEF to 0x10, AW and W ready together, BRESP OKAY.
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    check("w1_awvalid", bus.m_axi_awvalid, 1);
    check("w1_wvalid", bus.m_axi_wvalid, 1);
    check("w1_awaddr", bus.m_axi_awaddr, 32'h10);
    check("w1_wdata", bus.m_axi_wdata, 32'hDEAD_BEEF);
    check("w1_wstrb", bus.m_axi_wstrb, 4'hF);
    check("w1_cmd_ready", bus.cmd_ready, 0);
    check("w1_bready_early", bus.m_axi_bready, 0);
    tick();
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    check("w1_valids_drop", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 0);
    check("w1_bready", bus.m_axi_bready, 1);
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = 2'b00;
    tick();
    bus.m_axi_bvalid = 1'b0;
    check("w1_rsp_valid", bus.rsp_valid, 1);
    check("w1_rsp_we", bus.rsp_we, 1);
    check("w1_rsp_resp", bus.rsp_resp, 2'b00);
    check("w1_rsp_rdata", bus.rsp_rdata, 0);
    check("w1_bready_off", bus.m_axi_bready, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("w1_rsp_done", bus.rsp_valid, 0);
    check("w1_cmd_ready_back", bus.cmd_ready, 1);

    // AWREADY delayed 3 cycles, WREADY immediate, early BVALID with EXOKAY.
    bus.m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h14, 32'h1234_5678, 4'h3);
    check("w2_awvalid_c1", bus.m_axi_awvalid, 1);
    check("w2_wvalid_c1", bus.m_axi_wvalid, 1);
    tick();
    bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = 2'b01;
    check("w2_wvalid_drop", bus.m_axi_wvalid, 0);
    check("w2_awvalid_c2", bus.m_axi_awvalid, 1);
    check("w2_awaddr_stable", bus.m_axi_awaddr, 32'h14);
    check("w2_bready_c2", bus.m_axi_bready, 0);
    tick();
    check("w2_awvalid_c3", bus.m_axi_awvalid, 1);
    check("w2_early_b_ignored", {bus.m_axi_bready, bus.rsp_valid}, 0);
    tick();
    check("w2_awvalid_c4", bus.m_axi_awvalid, 1);
    bus.m_axi_awready = 1'b1;
    tick();
    bus.m_axi_awready = 1'b0;
    check("w2_awvalid_drop", bus.m_axi_awvalid, 0);
    check("w2_bready", bus.m_axi_bready, 1);
    check("w2_no_rsp_yet", bus.rsp_valid, 0);
    tick();
    bus.m_axi_bvalid = 1'b0;
    check("w2_rsp_valid", bus.rsp_valid, 1);
    check("w2_rsp_resp", bus.rsp_resp, 2'b01);
    check("w2_rsp_we", bus.rsp_we, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("w2_rsp_done", bus.rsp_valid, 0);
    tick();
    check("w2_single_rsp", bus.rsp_valid, 0);

    // Read 0x10, RVALID two cycles after the AR handshake.
    bus.m_axi_arready = 1'b1;
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    check("r1_arvalid", bus.m_axi_arvalid, 1);
    check("r1_araddr", bus.m_axi_araddr, 32'h10);
    check("r1_no_aw", bus.m_axi_awvalid, 0);
    tick();
    bus.m_axi_arready = 1'b0;
    check("r1_arvalid_drop", bus.m_axi_arvalid, 0);
    check("r1_rready", bus.m_axi_rready, 1);
    tick();
    check("r1_wait_rready", bus.m_axi_rready, 1);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = 32'hDEAD_BEEF;
    bus.m_axi_rresp  = 2'b00;
    tick();
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = 32'h0;
    check("r1_rsp_valid", bus.rsp_valid, 1);
    check("r1_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("r1_rsp_resp", bus.rsp_resp, 2'b00);
    check("r1_rsp_we", bus.rsp_we, 0);
    check("r1_rready_off", bus.m_axi_rready, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // SLVERR read, consumer stalls five cycles.
    bus.m_axi_arready = 1'b1;
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b1;
    bus.m_axi_rdata   = 32'hCAFE_F00D;
    bus.m_axi_rresp   = 2'b10;
    tick();
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = 32'h0;
    bus.m_axi_rresp  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check("r2_hold_valid", bus.rsp_valid, 1);
      check("r2_hold_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
      check("r2_hold_resp", bus.rsp_resp, 2'b10);
      check("r2_hold_cmd_ready", bus.cmd_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("r2_rsp_done", bus.rsp_valid, 0);
    check("r2_cmd_ready", bus.cmd_ready, 1);

    // Reset while ARVALID is high.
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    check("rst_mid_arvalid", bus.m_axi_arvalid, 1);
    ARESET = 1'b1;
    check("rst_mid_cmd_ready", bus.cmd_ready, 0);
    tick();
    check("rst_mid_arvalid_drop", bus.m_axi_arvalid, 0);
    check("rst_mid_rready", bus.m_axi_rready, 0);
    check("rst_mid_rsp_valid", bus.rsp_valid, 0);
    check("rst_mid_rsp_cleared", {bus.rsp_resp, bus.rsp_rdata}, 0);
    ARESET = 1'b0;
    tick();
    check("rst_mid_cmd_ready_back", bus.cmd_ready, 1);
    check("rst_mid_no_rsp", bus.rsp_valid, 0);

    // Slave never answers AR.
    send_cmd(1'b0, 32'h50, 32'h0, 4'h0);
`ifdef AXIL_MST_TIMEOUT_EN
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", n, 16);
    check("to_rsp_resp", bus.rsp_resp, 2'b10);
    check("to_rsp_rdata", bus.rsp_rdata, 0);
    check("to_arvalid", bus.m_axi_arvalid, 0);
    check("to_rready", bus.m_axi_rready, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("to_cmd_ready", bus.cmd_ready, 1);
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      seen = seen | bus.rsp_valid;
    end
    check("no_to_rsp", seen, 0);
    check("no_to_arvalid", bus.m_axi_arvalid, 1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    tick();
    check("no_to_recover", bus.cmd_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
